// File: rtl/l2_write_buffer_pkg.sv
// Shared types and address helpers for the L2 eviction write buffer.
package l2_wb_types;

    localparam int unsigned ADDR_WIDTH      = 16;
    localparam int unsigned LINE_WIDTH      = 256;
    localparam int unsigned OFFSET_BITS     = 5;
    localparam int unsigned LINE_ADDR_WIDTH = ADDR_WIDTH - OFFSET_BITS;

    typedef logic [ADDR_WIDTH-1:0]      addr_t;
    typedef logic [LINE_WIDTH-1:0]      line_t;
    typedef logic [LINE_ADDR_WIDTH-1:0] lineaddr_t;

    typedef enum logic [1:0] {IDLE, ACK, FWD_READ, DRAIN} wb_state_t;

    function automatic lineaddr_t line_of(addr_t a);
        return a[ADDR_WIDTH-1:OFFSET_BITS];
    endfunction

    function automatic addr_t line_base(lineaddr_t l);
        return {l, {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/l2_write_buffer_if.sv
// L2-side and pmem-side buses of the write buffer; slave is the buffer, master is
// the surrounding L2 controller plus memory.
interface l2_write_buffer_if;

    logic              l2_read;
    logic              l2_write;
    l2_wb_types::addr_t l2_address;
    l2_wb_types::line_t l2_wdata;
    logic              l2_resp;
    l2_wb_types::line_t l2_rdata;

    logic              pmem_read;
    logic              pmem_write;
    l2_wb_types::addr_t pmem_address;
    l2_wb_types::line_t pmem_wdata;
    logic              pmem_resp;
    l2_wb_types::line_t pmem_rdata;

    logic              wb_empty;

    modport slave (
        input  l2_read, l2_write, l2_address, l2_wdata, pmem_resp, pmem_rdata,
        output l2_resp, l2_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata, wb_empty
    );

    modport master (
        output l2_read, l2_write, l2_address, l2_wdata, pmem_resp, pmem_rdata,
        input  l2_resp, l2_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata, wb_empty
    );

endinterface

// File: rtl/l2_wb_storage.sv
// Line entry array kept in FIFO order (head + count) with a combinational
// line-address lookup used for both read hits and write coalescing.
module l2_wb_storage
    import l2_wb_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  lineaddr_t addr_i,
    input  line_t     data_i,
    input  logic      enq_i,
    input  logic      coal_i,
    input  logic      pop_i,
    output logic      hit_o,
    output line_t     hit_data_o,
    output lineaddr_t head_addr_o,
    output line_t     head_data_o,
    output logic      empty_o,
    output logic      full_o,
    output logic      last_o
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic [DEPTH-1:0] valid_q;
    lineaddr_t        addr_q [DEPTH];
    line_t            data_q [DEPTH];
    logic [IdxW-1:0]  head_q;
    logic [CntW-1:0]  count_q;
    logic [IdxW-1:0]  tail;
    logic [IdxW-1:0]  hit_idx;

    assign tail = IdxW'((32'(head_q) + 32'(count_q)) % DEPTH);

    // Coalescing guarantees at most one valid entry matches a given line.
    always_comb begin
        hit_o   = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == addr_i)) begin
                hit_o   = 1'b1;
                hit_idx = IdxW'(i);
            end
        end
    end

    assign hit_data_o  = data_q[hit_idx];
    assign head_addr_o = addr_q[head_q];
    assign head_data_o = data_q[head_q];
    assign empty_o     = (count_q == '0);
    assign full_o      = (count_q == CntW'(DEPTH));
    assign last_o      = (count_q == CntW'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            head_q  <= '0;
            count_q <= '0;
        end else if (enq_i) begin
            valid_q[tail] <= 1'b1;
            count_q       <= count_q + CntW'(1);
        end else if (pop_i) begin
            valid_q[head_q] <= 1'b0;
            head_q          <= IdxW'((32'(head_q) + 32'd1) % DEPTH);
            count_q         <= count_q - CntW'(1);
        end
    end

    // Payload is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (enq_i) begin
            addr_q[tail] <= addr_i;
            data_q[tail] <= data_i;
        end else if (coal_i) begin
            data_q[hit_idx] <= data_i;
        end
    end

endmodule

// File: rtl/l2_write_buffer.sv
// Eviction write buffer between L2 and pmem: 1-cycle writeback acks, idle-time
// draining, and read forwarding that is served from the buffer on a line hit.
module l2_write_buffer
    import l2_wb_types::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input logic              clk_i,
    input logic              rst_i,
    l2_write_buffer_if.slave bus_io
);

    wb_state_t state_q;
    logic      ack_q;
    logic      pmem_read_q;
    logic      pmem_write_q;
    logic      wb_empty_q;
    addr_t     pmem_address_q;
    line_t     pmem_wdata_q;
    line_t     rdata_q;

    logic      hit;
    logic      empty;
    logic      full;
    logic      last;
    logic      enq;
    logic      coal;
    logic      pop;
    line_t     hit_data;
    line_t     head_data;
    lineaddr_t head_addr;

    // Storage strobes mirror the IDLE priority: reads win over writes.
    always_comb begin
        enq  = 1'b0;
        coal = 1'b0;
        pop  = 1'b0;
        if (state_q == IDLE && !bus_io.l2_read && bus_io.l2_write) begin
            coal = hit;
            enq  = !hit && !full;
        end
        if (state_q == DRAIN) begin
            pop = bus_io.pmem_resp;
        end
    end

    l2_wb_storage #(
        .DEPTH(DEPTH)
    ) u_storage (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .addr_i     (line_of(bus_io.l2_address)),
        .data_i     (bus_io.l2_wdata),
        .enq_i      (enq),
        .coal_i     (coal),
        .pop_i      (pop),
        .hit_o      (hit),
        .hit_data_o (hit_data),
        .head_addr_o(head_addr),
        .head_data_o(head_data),
        .empty_o    (empty),
        .full_o     (full),
        .last_o     (last)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= IDLE;
            ack_q          <= 1'b0;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            wb_empty_q     <= 1'b1;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            rdata_q        <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus_io.l2_read) begin
                        if (hit) begin
                            rdata_q <= hit_data;
                            ack_q   <= 1'b1;
                            state_q <= ACK;
                        end else begin
                            pmem_read_q    <= 1'b1;
                            pmem_address_q <= line_base(line_of(bus_io.l2_address));
                            state_q        <= FWD_READ;
                        end
                    end else if (bus_io.l2_write && (hit || !full)) begin
                        ack_q      <= 1'b1;
                        wb_empty_q <= 1'b0;
                        state_q    <= ACK;
                    end else if (bus_io.l2_write || !empty) begin
                        // A write into a full buffer stays pending until this drain frees a slot.
                        pmem_write_q   <= 1'b1;
                        pmem_address_q <= line_base(head_addr);
                        pmem_wdata_q   <= head_data;
                        state_q        <= DRAIN;
                    end
                end
                ACK: begin
                    ack_q   <= 1'b0;
                    state_q <= IDLE;
                end
                FWD_READ: begin
                    if (bus_io.pmem_resp) begin
                        pmem_read_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                DRAIN: begin
                    if (bus_io.pmem_resp) begin
                        pmem_write_q <= 1'b0;
                        if (last) begin
                            wb_empty_q <= 1'b1;
                        end
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Forwarded reads complete with pmem in the same cycle, no extra latency.
    assign bus_io.l2_resp      = ack_q || (state_q == FWD_READ && bus_io.pmem_resp);
    assign bus_io.l2_rdata     = (state_q == FWD_READ) ? bus_io.pmem_rdata : rdata_q;
    assign bus_io.pmem_read    = pmem_read_q;
    assign bus_io.pmem_write   = pmem_write_q;
    assign bus_io.pmem_address = pmem_address_q;
    assign bus_io.pmem_wdata   = pmem_wdata_q;
    assign bus_io.wb_empty     = wb_empty_q;

endmodule

// File: tb/tb_l2_write_buffer.sv
// Bench for l2_write_buffer: directed scenarios plus random L2 traffic checked
// against a coherent-memory view and a coalescing FIFO model of buffered lines.
module tb_l2_write_buffer;
    import l2_wb_types::*;

    localparam int unsigned DEPTH = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l2_write_buffer_if bus ();

    l2_write_buffer #(
        .DEPTH(DEPTH)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [LINE_WIDTH-1:0] got,
                       input logic [LINE_WIDTH-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        lineaddr_t line;
        line_t     data;
    } ent_t;

    ent_t  mq[$];
    line_t truth[lineaddr_t];
    line_t pmem_mem[lineaddr_t];
    addr_t wr_log[$];
    int    wr_done        = 0;
    int    rd_cycles      = 0;
    int    last_rd_cycles = 0;
    int    resp_delay     = 0;
    int    wait_cnt       = 0;

    function automatic line_t mem_init(lineaddr_t l);
        line_t v;
        for (int i = 0; i < 8; i++) v[i*32+:32] = {5'(i), 16'(l), 11'h2A5} ^ 32'h6B8B_4567;
        return v;
    endfunction

    function automatic line_t mem_rd(lineaddr_t l);
        return pmem_mem.exists(l) ? pmem_mem[l] : mem_init(l);
    endfunction

    function automatic line_t truth_rd(lineaddr_t l);
        return truth.exists(l) ? truth[l] : mem_init(l);
    endfunction

    function automatic int q_find(lineaddr_t l);
        foreach (mq[i]) if (mq[i].line == l) return i;
        return -1;
    endfunction

    function automatic line_t rand_line();
        line_t v;
        for (int i = 0; i < 8; i++) v[i*32+:32] = $urandom;
        return v;
    endfunction

    // Physical memory: answers after resp_delay extra cycles.
    initial begin
        bus.pmem_resp  = 1'b0;
        bus.pmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst || !(bus.pmem_read || bus.pmem_write) || bus.pmem_resp) begin
                bus.pmem_resp = 1'b0;
                wait_cnt      = 0;
            end else if (wait_cnt >= resp_delay) begin
                bus.pmem_resp = 1'b1;
                if (bus.pmem_read) bus.pmem_rdata = mem_rd(line_of(bus.pmem_address));
                else pmem_mem[line_of(bus.pmem_address)] = bus.pmem_wdata;
            end else begin
                wait_cnt++;
            end
        end
    end

    // Monitor: L2 must always see the latest written data; drains leave in FIFO order.
    initial begin
        lineaddr_t l;
        int        idx;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                mq.delete();
                truth     = pmem_mem;
                rd_cycles = 0;
            end else begin
                chk("rw_excl", bus.pmem_read & bus.pmem_write, 0);
                if (bus.pmem_read) begin
                    rd_cycles++;
                    chk("rd_addr", bus.pmem_address, line_base(line_of(bus.l2_address)));
                end
                if (bus.pmem_read && bus.pmem_resp) chk("rd_resp_coinc", bus.l2_resp, 1);
                if (bus.l2_resp) begin
                    l = line_of(bus.l2_address);
                    if (bus.l2_read) begin
                        chk("rd_data", bus.l2_rdata, truth_rd(l));
                        if (q_find(l) >= 0) chk("hit_no_pmem", rd_cycles, 0);
                        else chk("miss_pmem", rd_cycles != 0, 1);
                    end else if (bus.l2_write) begin
                        truth[l] = bus.l2_wdata;
                        idx      = q_find(l);
                        if (idx >= 0) begin
                            mq[idx].data = bus.l2_wdata;
                        end else begin
                            chk("overflow", mq.size() < DEPTH, 1);
                            mq.push_back('{l, bus.l2_wdata});
                        end
                    end else begin
                        chk("resp_no_req", bus.l2_resp, 0);
                    end
                    last_rd_cycles = rd_cycles;
                    rd_cycles      = 0;
                end
                chk("wb_empty", bus.wb_empty, mq.size() == 0);
                if (bus.pmem_write && bus.pmem_resp) begin
                    if (mq.size() == 0) begin
                        chk("drain_unexpected", bus.pmem_write, 0);
                    end else begin
                        chk("drain_addr", bus.pmem_address, line_base(mq[0].line));
                        chk("drain_data", bus.pmem_wdata, mq[0].data);
                        void'(mq.pop_front());
                    end
                    wr_log.push_back(bus.pmem_address);
                    wr_done++;
                end
            end
        end
    end

    task automatic l2_req(input logic wr, input addr_t a, input line_t d, output int lat,
                          output line_t rd);
        @(negedge clk);
        #2;
        bus.l2_read    = !wr;
        bus.l2_write   = wr;
        bus.l2_address = a;
        bus.l2_wdata   = d;
        lat            = -1;
        rd             = '0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge clk);
            #2;
            if (bus.l2_resp) begin
                lat = i;
                rd  = bus.l2_rdata;
                break;
            end
        end
        bus.l2_read  = 1'b0;
        bus.l2_write = 1'b0;
        if (lat < 0) chk("req_timeout", bus.l2_resp, 1);
    endtask

    task automatic wait_empty();
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            if (bus.wb_empty && !bus.pmem_write && !bus.pmem_read) return;
        end
        chk("empty_timeout", bus.wb_empty, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int    lat;
        int    base;
        line_t rd;
        line_t d1;
        line_t d2;
        bus.l2_read    = 1'b0;
        bus.l2_write   = 1'b0;
        bus.l2_address = '0;
        bus.l2_wdata   = '0;
        d1             = rand_line();
        d2             = rand_line();

        repeat (3) @(negedge clk);
        #3 rst = 1'b0;
        repeat (5) @(negedge clk);
        #2;
        chk("rst_wb_empty", bus.wb_empty, 1);
        chk("rst_pmem_read", bus.pmem_read, 0);
        chk("rst_pmem_write", bus.pmem_write, 0);
        chk("rst_l2_resp", bus.l2_resp, 0);
        chk("rst_pmem_addr", bus.pmem_address, 0);

        // Single writeback, then drain to the line-aligned address.
        wr_log.delete();
        l2_req(1'b1, 16'h1234, d1, lat, rd);
        chk("wr_lat", lat, 1);
        chk("wr_nonempty", bus.wb_empty, 0);
        wait_empty();
        chk("drain1_cnt", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("drain1_addr", wr_log[0], 16'h1220);
        chk("drain1_data", mem_rd(line_of(16'h1220)), d1);

        // Read hit served from the buffer.
        l2_req(1'b1, 16'h1220, d1, lat, rd);
        l2_req(1'b0, 16'h123F, '0, lat, rd);
        chk("hit_lat", lat, 1);
        chk("hit_data", rd, d1);
        chk("hit_rd_cycles", last_rd_cycles, 0);
        wait_empty();

        // Coalescing two writes to the same line.
        wr_log.delete();
        l2_req(1'b1, 16'h0040, d1, lat, rd);
        l2_req(1'b1, 16'h0050, d2, lat, rd);
        wait_empty();
        chk("coal_cnt", wr_log.size(), 1);
        if (wr_log.size() > 0) chk("coal_addr", wr_log[0], 16'h0040);
        chk("coal_data", mem_rd(line_of(16'h0040)), d2);

        // Full buffer: third write waits for the oldest drain.
        resp_delay = 4;
        wr_log.delete();
        l2_req(1'b1, 16'h0000, d1, lat, rd);
        l2_req(1'b1, 16'h0020, d2, lat, rd);
        base = wr_done;
        l2_req(1'b1, 16'h0040, d1 ^ d2, lat, rd);
        chk("full_drained", wr_done - base, 1);
        chk("full_lat", lat, 7);
        wait_empty();
        chk("order_cnt", wr_log.size(), 3);
        if (wr_log.size() == 3) begin
            chk("order0", wr_log[0], 16'h0000);
            chk("order1", wr_log[1], 16'h0020);
            chk("order2", wr_log[2], 16'h0040);
        end

        // Read miss forwarded to pmem.
        resp_delay = 2;
        l2_req(1'b0, 16'h8000, '0, lat, rd);
        chk("miss_lat", lat, 3);
        chk("miss_rd_cycles", last_rd_cycles, 3);
        chk("miss_data", rd, mem_init(line_of(16'h8000)));

        // Reset in the middle of a drain discards the buffered line.
        resp_delay = 6;
        l2_req(1'b1, 16'h0100, d2, lat, rd);
        lat = 0;
        for (int i = 0; i < 20 && !bus.pmem_write; i++) begin
            @(negedge clk);
            #2;
        end
        chk("drain_started", bus.pmem_write, 1);
        @(negedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_drain_write", bus.pmem_write, 0);
        chk("rst_drain_empty", bus.wb_empty, 1);
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        resp_delay = 0;
        l2_req(1'b0, 16'h0100, '0, lat, rd);
        chk("rst_discard_data", rd, mem_init(line_of(16'h0100)));

        // Random traffic over a small set of lines to stress hits and coalescing.
        for (int n = 0; n < 300; n++) begin
            addr_t a;
            logic  wr;
            resp_delay = $urandom_range(0, 3);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a  = addr_t'(($urandom_range(0, 5) << 5) | $urandom_range(0, 31));
            wr = 1'($urandom_range(0, 1));
            l2_req(wr, a, rand_line(), lat, rd);
        end
        wait_empty();
        chk("final_empty", bus.wb_empty, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
